bit_index_decoder: RTL and testbench

Sequential decoder that accepts a WIDTH-bit mask and emits the binary index (and one-hot form) of every set bit, one per output beat, lowest bit first. It is the inverse companion of the priority encoder: the encoder reduces a vector to a one-hot pick, and this block expands a vector back into an ordered stream of indexes. It sits between mask-producing logic and per-index consumers such as arbiters, request walkers and scatter engines.

---
 rtl/bit_index_decoder.sv | 96 +++++++++
 tb/tb_bit_index_decoder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bit_index_decoder.sv
// Expands a WIDTH-bit mask into a stream of per-bit index beats, lowest bit first.
// Define BIT_INDEX_DECODER_MSB_FIRST_EN to emit the highest set bit first instead.
module bit_index_decoder #(
    parameter int WIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       srst_n_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       data_val_i,
    output logic                       data_ready_o,
    output logic [$clog2(WIDTH)-1:0]   idx_o,
    output logic [WIDTH-1:0]           idx_onehot_o,
    output logic                       idx_val_o,
    output logic                       idx_last_o,
    output logic                       idx_empty_o,
    input  logic                       idx_ready_i
);

    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   rem;
    logic               empty;
    logic [WIDTH-1:0]   pick;
    logic [IDX_W-1:0]   pick_idx;
    logic               at_most_one;
    logic               busy;

    // Select the bit to emit this beat; zero when rem is empty.
    always_comb begin
`ifdef BIT_INDEX_DECODER_MSB_FIRST_EN
        pick = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (rem[i]) begin
                pick = WIDTH'(1) << i;
            end
        end
`else
        pick = rem & (~rem + WIDTH'(1));
`endif
    end

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pick[i]) begin
                pick_idx = pick_idx | IDX_W'(i);
            end
        end
    end

    assign at_most_one = ((rem & (rem - WIDTH'(1))) == '0);
    assign busy        = (state == BUSY);

    assign data_ready_o = !busy;
    assign idx_val_o    = busy;
    assign idx_last_o   = busy && at_most_one;
    assign idx_empty_o  = busy && empty;
    assign idx_onehot_o = busy ? pick : '0;
    assign idx_o        = busy ? pick_idx : '0;

    // Capture a mask in IDLE, then retire one set bit per accepted beat.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state <= IDLE;
            rem   <= '0;
            empty <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_val_i) begin
                        rem   <= data_i;
                        empty <= (data_i == '0);
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (idx_ready_i) begin
                        rem <= rem & ~pick;
                        if (at_most_one) begin
                            empty <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_index_decoder.sv
// Table-driven bench for bit_index_decoder (WIDTH=16), plus a bounded full-mask walk.
// Honors BIT_INDEX_DECODER_MSB_FIRST_EN for the expected beat order.
module tb_bit_index_decoder;

    logic        clk;
    logic        srst_n;
    logic [15:0] data;
    logic        data_val;
    logic        data_ready;
    logic [3:0]  idx;
    logic [15:0] idx_onehot;
    logic        idx_val;
    logic        idx_last;
    logic        idx_empty;
    logic        idx_ready;

    int checks_total;
    int checks_passed;

    typedef struct {
        logic        rst_n;
        logic        val;
        logic [15:0] din;
        logic        rdy;
        logic        e_dr;
        logic        e_iv;
        logic [3:0]  e_idx;
        logic [15:0] e_oh;
        logic        e_last;
        logic        e_empty;
    } vec_t;

    vec_t vecs[$];

    bit_index_decoder #(.WIDTH(16)) dut (
        .clk_i        (clk),
        .srst_n_i     (srst_n),
        .data_i       (data),
        .data_val_i   (data_val),
        .data_ready_o (data_ready),
        .idx_o        (idx),
        .idx_onehot_o (idx_onehot),
        .idx_val_o    (idx_val),
        .idx_last_o   (idx_last),
        .idx_empty_o  (idx_empty),
        .idx_ready_i  (idx_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic r, input logic v, input logic [15:0] d, input logic rd,
                                input logic dr, input logic iv, input logic [3:0] ix,
                                input logic [15:0] oh, input logic l, input logic e);
        vec_t t;
        t.rst_n = r;  t.val = v;   t.din = d;    t.rdy = rd;
        t.e_dr = dr;  t.e_iv = iv; t.e_idx = ix; t.e_oh = oh;
        t.e_last = l; t.e_empty = e;
        return t;
    endfunction

    task automatic applyStimulus(input logic r, input logic v, input logic [15:0] d, input logic rd);
        srst_n    = r;
        data_val  = v;
        data      = d;
        idx_ready = rd;
    endtask

    task automatic checkOutput(input string name, input int row, input logic [15:0] act,
                               input logic [15:0] exp);
        checks_total++;
        if (act !== exp)
            $display("[TB] FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
        else
            checks_passed++;
    endtask

    initial begin
        int beats;
        bit done;

        checks_total  = 0;
        checks_passed = 0;

        // Cycle-by-cycle vectors: inputs held for one cycle, outputs expected during it.
        vecs.push_back(mk(0, 1, 16'hFFFF, 1,  1, 0, 4'd0,  16'h0000, 0, 0));
        vecs.push_back(mk(1, 0, 16'h0000, 1,  1, 0, 4'd0,  16'h0000, 0, 0));
        vecs.push_back(mk(1, 1, 16'h8421, 1,  1, 0, 4'd0,  16'h0000, 0, 0));
`ifdef BIT_INDEX_DECODER_MSB_FIRST_EN
        vecs.push_back(mk(1, 0, 16'h0000, 1,  0, 1, 4'd15, 16'h8000, 0, 0));
        vecs.push_back(mk(1, 0, 16'h0000, 1,  0, 1, 4'd10, 16'h0400, 0, 0));
        vecs.push_back(mk(1, 0, 16'h0000, 1,  0, 1, 4'd5,  16'h0020, 0, 0));
        vecs.push_back(mk(1, 0, 16'h0000, 1,  0, 1, 4'd0,  16'h0001, 1, 0));
`else
        vecs.push_back(mk(1, 0, 16'h0000, 1,  0, 1, 4'd0,  16'h0001, 0, 0));
        vecs.push_back(mk(1, 0, 16'h0000, 1,  0, 1, 4'd5,  16'h0020, 0, 0));
        vecs.push_back(mk(1, 0, 16'h0000, 1,  0, 1, 4'd10, 16'h0400, 0, 0));
        vecs.push_back(mk(1, 0, 16'h0000, 1,  0, 1, 4'd15, 16'h8000, 1, 0));
`endif
        vecs.push_back(mk(1, 1, 16'h0000, 1,  1, 0, 4'd0,  16'h0000, 0, 0));
        vecs.push_back(mk(1, 0, 16'h0000, 1,  0, 1, 4'd0,  16'h0000, 1, 1));
        vecs.push_back(mk(1, 1, 16'h0006, 0,  1, 0, 4'd0,  16'h0000, 0, 0));
`ifdef BIT_INDEX_DECODER_MSB_FIRST_EN
        vecs.push_back(mk(1, 1, 16'hFFFF, 0,  0, 1, 4'd2,  16'h0004, 0, 0));
        vecs.push_back(mk(1, 1, 16'hFFFF, 0,  0, 1, 4'd2,  16'h0004, 0, 0));
        vecs.push_back(mk(1, 0, 16'h0000, 0,  0, 1, 4'd2,  16'h0004, 0, 0));
        vecs.push_back(mk(1, 1, 16'hFFFF, 1,  0, 1, 4'd2,  16'h0004, 0, 0));
        vecs.push_back(mk(1, 1, 16'hFFFF, 1,  0, 1, 4'd1,  16'h0002, 1, 0));
`else
        vecs.push_back(mk(1, 1, 16'hFFFF, 0,  0, 1, 4'd1,  16'h0002, 0, 0));
        vecs.push_back(mk(1, 1, 16'hFFFF, 0,  0, 1, 4'd1,  16'h0002, 0, 0));
        vecs.push_back(mk(1, 0, 16'h0000, 0,  0, 1, 4'd1,  16'h0002, 0, 0));
        vecs.push_back(mk(1, 1, 16'hFFFF, 1,  0, 1, 4'd1,  16'h0002, 0, 0));
        vecs.push_back(mk(1, 1, 16'hFFFF, 1,  0, 1, 4'd2,  16'h0004, 1, 0));
`endif
        vecs.push_back(mk(1, 0, 16'h0000, 1,  1, 0, 4'd0,  16'h0000, 0, 0));
        vecs.push_back(mk(1, 1, 16'hFFFF, 1,  1, 0, 4'd0,  16'h0000, 0, 0));
`ifdef BIT_INDEX_DECODER_MSB_FIRST_EN
        vecs.push_back(mk(1, 0, 16'h0000, 1,  0, 1, 4'd15, 16'h8000, 0, 0));
        vecs.push_back(mk(0, 1, 16'h0100, 1,  0, 1, 4'd14, 16'h4000, 0, 0));
`else
        vecs.push_back(mk(1, 0, 16'h0000, 1,  0, 1, 4'd0,  16'h0001, 0, 0));
        vecs.push_back(mk(0, 1, 16'h0100, 1,  0, 1, 4'd1,  16'h0002, 0, 0));
`endif
        vecs.push_back(mk(0, 0, 16'h0000, 1,  1, 0, 4'd0,  16'h0000, 0, 0));
        vecs.push_back(mk(1, 1, 16'h0100, 1,  1, 0, 4'd0,  16'h0000, 0, 0));
        vecs.push_back(mk(1, 0, 16'h0000, 1,  0, 1, 4'd8,  16'h0100, 1, 0));
        vecs.push_back(mk(1, 0, 16'h0000, 1,  1, 0, 4'd0,  16'h0000, 0, 0));

        applyStimulus(0, 0, 16'h0000, 1);
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i].rst_n, vecs[i].val, vecs[i].din, vecs[i].rdy);
            #1;
            checkOutput("data_ready", i, {15'd0, data_ready}, {15'd0, vecs[i].e_dr});
            checkOutput("idx_val",    i, {15'd0, idx_val},    {15'd0, vecs[i].e_iv});
            checkOutput("idx",        i, {12'd0, idx},        {12'd0, vecs[i].e_idx});
            checkOutput("idx_onehot", i, idx_onehot,          vecs[i].e_oh);
            checkOutput("idx_last",   i, {15'd0, idx_last},   {15'd0, vecs[i].e_last});
            checkOutput("idx_empty",  i, {15'd0, idx_empty},  {15'd0, vecs[i].e_empty});
        end

        // Full mask with ready held high: 16 beats in consecutive cycles, bounded wait.
        @(negedge clk);
        applyStimulus(1, 1, 16'hFFFF, 1);
        @(negedge clk);
        applyStimulus(1, 0, 16'h0000, 1);
        beats = 0;
        done  = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            checkOutput("walk_val", 100 + beats, {15'd0, idx_val}, 16'd1);
`ifdef BIT_INDEX_DECODER_MSB_FIRST_EN
            checkOutput("walk_idx", 100 + beats, {12'd0, idx}, 16'(15 - beats));
`else
            checkOutput("walk_idx", 100 + beats, {12'd0, idx}, 16'(beats));
`endif
            beats++;
            if (idx_last === 1'b1 || !idx_val)
                done = 1;
            else
                @(negedge clk);
        end
        checkOutput("walk_beats", 200, 16'(beats), 16'd16);
        checkOutput("walk_done", 201, {15'd0, done}, 16'd1);
        @(negedge clk);
        #1;
        checkOutput("walk_ready_after", 202, {15'd0, data_ready}, 16'd1);
        checkOutput("walk_val_after", 203, {15'd0, idx_val}, 16'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
